// File: rtl/hsb_mipi_hdr_inserter.sv
// Purpose : prepends a CSI-2 packet header beat to an AXI-Stream payload.
// Latency : one cycle from header or payload acceptance to m_axis_tvalid.
// Backpr. : one registered output stage; hdr_ready/s_axis_tready drop while it is stalled.
//
// Ports:
//   axis_aclk / axis_aresetn   clock, asynchronous active-low reset
//   hdr_*                      header request (dt, vc, wc), consumed on hdr_ready
//   s_axis_*                   payload input stream (accepted only in PAYLOAD)
//   m_axis_*                   output stream; tuser[0] marks the header beat
//   pkt_count                  headers emitted (wraps)
//   wc_err_count               word-count mismatches (saturating)
// Optional feature: define HSB_MIPI_HDR_INS_WC_CHECK_EN to enable word-count
// checking of long packets; without it wc_err_count is tied to 0.
module hsb_mipi_hdr_inserter #(
    parameter int         C_AXIS_TUSER_WIDTH = 1,
    parameter int         C_AXIS_TDATA_WIDTH = 64,
    parameter logic [5:0] LONG_DT_MIN        = 6'h10
) (
    input  logic                            axis_aclk,
    input  logic                            axis_aresetn,
    input  logic                            hdr_valid,
    output logic                            hdr_ready,
    input  logic [5:0]                      hdr_dt,
    input  logic [1:0]                      hdr_vc,
    input  logic [15:0]                     hdr_wc,
    input  logic [C_AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [C_AXIS_TDATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    input  logic                            s_axis_tlast,
    output logic [C_AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
    output logic [C_AXIS_TDATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic                            m_axis_tlast,
    output logic [31:0]                     pkt_count,
    output logic [15:0]                     wc_err_count
);

    localparam int KEEP_W = C_AXIS_TDATA_WIDTH / 8;

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_PAYLOAD = 1'b1;

    logic [0:0]                    state_q,    state_d;
    logic                          out_vld_q,  out_vld_d;
    logic [C_AXIS_TDATA_WIDTH-1:0] out_dat_q,  out_dat_d;
    logic [KEEP_W-1:0]             out_keep_q, out_keep_d;
    logic                          out_user_q, out_user_d;
    logic                          out_last_q, out_last_d;
    logic [31:0]                   pkt_cnt_q,  pkt_cnt_d;

    logic out_free;
    logic hdr_load;
    logic pay_acc;
    logic hdr_short;

    always_comb begin
        out_free  = !out_vld_q || m_axis_tready;
        // Reset gating keeps hdr_ready low while the block is held in reset.
        hdr_load  = axis_aresetn && (state_q == ST_IDLE) && hdr_valid && out_free;
        pay_acc   = (state_q == ST_PAYLOAD) && out_free && s_axis_tvalid;
        // Short data types and zero-length long packets have no payload phase.
        hdr_short = (hdr_dt < LONG_DT_MIN) || (hdr_wc == 16'd0);

        state_d    = state_q;
        out_vld_d  = out_vld_q;
        out_dat_d  = out_dat_q;
        out_keep_d = out_keep_q;
        out_user_d = out_user_q;
        out_last_d = out_last_q;
        pkt_cnt_d  = pkt_cnt_q;

        if (out_free) begin
            out_vld_d = 1'b0;
        end

        if (hdr_load) begin
            out_vld_d        = 1'b1;
            out_dat_d        = '0;
            out_dat_d[23:0]  = {hdr_wc, hdr_vc, hdr_dt};
            out_keep_d       = '1;
            out_user_d       = 1'b1;
            out_last_d       = hdr_short;
            pkt_cnt_d        = pkt_cnt_q + 32'd1;
            if (!hdr_short) begin
                state_d = ST_PAYLOAD;
            end
        end else if (pay_acc) begin
            out_vld_d  = 1'b1;
            out_dat_d  = s_axis_tdata;
            out_keep_d = s_axis_tkeep;
            out_user_d = 1'b0;
            out_last_d = s_axis_tlast;
            if (s_axis_tlast) begin
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            state_q    <= ST_IDLE;
            out_vld_q  <= 1'b0;
            out_dat_q  <= '0;
            out_keep_q <= '0;
            out_user_q <= 1'b0;
            out_last_q <= 1'b0;
            pkt_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            out_vld_q  <= out_vld_d;
            out_dat_q  <= out_dat_d;
            out_keep_q <= out_keep_d;
            out_user_q <= out_user_d;
            out_last_q <= out_last_d;
            pkt_cnt_q  <= pkt_cnt_d;
        end
    end

`ifdef HSB_MIPI_HDR_INS_WC_CHECK_EN
    logic [15:0] beat_cnt_q,  beat_cnt_d;
    logic [15:0] exp_beats_q, exp_beats_d;
    logic [3:0]  exp_keep_q,  exp_keep_d;
    logic [15:0] err_cnt_q,   err_cnt_d;
    logic [16:0] wc_round_up;
    logic [3:0]  keep_ones;
    logic [15:0] beat_cnt_inc;

    always_comb begin
        wc_round_up  = {1'b0, hdr_wc} + 17'd7;
        beat_cnt_inc = beat_cnt_q + 16'd1;
        keep_ones    = 4'd0;
        for (int i = 0; i < KEEP_W; i++) begin
            keep_ones = keep_ones + {3'b000, s_axis_tkeep[i]};
        end

        beat_cnt_d  = beat_cnt_q;
        exp_beats_d = exp_beats_q;
        exp_keep_d  = exp_keep_q;
        err_cnt_d   = err_cnt_q;

        if (hdr_load) begin
            beat_cnt_d  = 16'd0;
            exp_beats_d = {2'b00, wc_round_up[16:3]};
            // A word count that is a multiple of 8 ends on a full beat.
            exp_keep_d  = (hdr_wc[2:0] == 3'd0) ? 4'd8 : {1'b0, hdr_wc[2:0]};
        end else if (pay_acc) begin
            beat_cnt_d = beat_cnt_inc;
            if (s_axis_tlast && ((beat_cnt_inc != exp_beats_q) || (keep_ones != exp_keep_q))
                && (err_cnt_q != 16'hFFFF)) begin
                err_cnt_d = err_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            beat_cnt_q  <= '0;
            exp_beats_q <= '0;
            exp_keep_q  <= '0;
            err_cnt_q   <= '0;
        end else begin
            beat_cnt_q  <= beat_cnt_d;
            exp_beats_q <= exp_beats_d;
            exp_keep_q  <= exp_keep_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign wc_err_count = err_cnt_q;
`else
    assign wc_err_count = 16'd0;
`endif

    assign hdr_ready     = hdr_load;
    assign s_axis_tready = (state_q == ST_PAYLOAD) && out_free;
    assign m_axis_tvalid = out_vld_q;
    assign m_axis_tdata  = out_dat_q;
    assign m_axis_tkeep  = out_keep_q;
    assign m_axis_tlast  = out_last_q;
    assign pkt_count     = pkt_cnt_q;

    always_comb begin
        m_axis_tuser    = '0;
        m_axis_tuser[0] = out_user_q;
    end

endmodule

// File: tb/tb_hsb_mipi_hdr_inserter.sv
// Purpose : scoreboard bench for hsb_mipi_hdr_inserter with directed packets.
// Latency : expected beats are queued on acceptance and popped when the DUT presents them.
// Backpr. : m_axis_tready is held high or toggled 1010... by a dedicated driver.
`timescale 1ns/1ps
module tb_hsb_mipi_hdr_inserter;

    typedef struct packed {
        logic [63:0] dat;
        logic [7:0]  keep;
        logic        user;
        logic        last;
    } beat_t;

    logic        axis_aclk     = 1'b0;
    logic        axis_aresetn  = 1'b0;
    logic        hdr_valid     = 1'b0;
    logic        hdr_ready;
    logic [5:0]  hdr_dt        = '0;
    logic [1:0]  hdr_vc        = '0;
    logic [15:0] hdr_wc        = '0;
    logic [63:0] s_axis_tdata  = '0;
    logic [7:0]  s_axis_tkeep  = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic        s_axis_tlast  = 1'b0;
    logic [63:0] m_axis_tdata;
    logic [7:0]  m_axis_tkeep;
    logic [0:0]  m_axis_tuser;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic        m_axis_tlast;
    logic [31:0] pkt_count;
    logic [15:0] wc_err_count;

`ifdef HSB_MIPI_HDR_INS_WC_CHECK_EN
    localparam logic [15:0] WC_ERR_AFTER_SHORT = 16'd1;
`else
    localparam logic [15:0] WC_ERR_AFTER_SHORT = 16'd0;
`endif

    hsb_mipi_hdr_inserter #(
        .C_AXIS_TUSER_WIDTH (1),
        .C_AXIS_TDATA_WIDTH (64),
        .LONG_DT_MIN        (6'h10)
    ) dut (
        .axis_aclk     (axis_aclk),
        .axis_aresetn  (axis_aresetn),
        .hdr_valid     (hdr_valid),
        .hdr_ready     (hdr_ready),
        .hdr_dt        (hdr_dt),
        .hdr_vc        (hdr_vc),
        .hdr_wc        (hdr_wc),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .pkt_count     (pkt_count),
        .wc_err_count  (wc_err_count)
    );

    always #5 axis_aclk = ~axis_aclk;

    int    total        = 0;
    int    bad          = 0;
    int    cyc          = 0;
    int    model_pkts   = 0;
    int    hdr_cyc      = -1;
    int    pay_last_cyc = -1;
    logic  tgl_en       = 1'b0;
    beat_t exp_q[$];

    always @(posedge axis_aclk) cyc++;

    // Sink ready driver: steady high, or alternating when backpressure is enabled.
    always @(posedge axis_aclk) begin
        #1;
        if (tgl_en) m_axis_tready = ~m_axis_tready;
        else        m_axis_tready = 1'b1;
    end

    // Monitor: compares every transferred beat against the scoreboard and
    // checks that a stalled beat holds still.
    beat_t held;
    logic  stalled = 1'b0;
    always @(negedge axis_aclk) begin
        beat_t act;
        beat_t e;
        act = {m_axis_tdata, m_axis_tkeep, m_axis_tuser[0], m_axis_tlast};
        if (stalled && m_axis_tvalid) begin
            total++;
            if (act !== held) begin
                bad++;
                $display("FAIL stall_hold act=%h req=%h", act, held);
            end
        end
        stalled = m_axis_tvalid && !m_axis_tready;
        held    = act;
        if (m_axis_tvalid && m_axis_tready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_beat act=%h req=none", act);
            end else begin
                e = exp_q.pop_front();
                if (act !== e) begin
                    bad++;
                    $display("FAIL beat act=%h req=%h", act, e);
                end
            end
            if (act.user)      hdr_cyc      = cyc;
            else if (act.last) pay_last_cyc = cyc;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s act=%h req=%h", name, act, req);
        end
    endtask

    // Header with a hand-computed expected beat.
    task automatic send_hdr(input logic [5:0] dt, input logic [1:0] vc, input logic [15:0] wc,
                            input logic [63:0] req_dat, input logic req_last);
        int n;
        n = 0;
        hdr_dt = dt; hdr_vc = vc; hdr_wc = wc; hdr_valid = 1'b1;
        @(negedge axis_aclk);
        while (!hdr_ready && n < 4000) begin
            n++;
            @(negedge axis_aclk);
        end
        if (!hdr_ready) begin
            total++; bad++;
            $display("FAIL hdr_timeout act=no_ready req=ready");
        end else begin
            exp_q.push_back({req_dat, 8'hFF, 1'b1, req_last});
            model_pkts++;
        end
        @(posedge axis_aclk); #1;
        hdr_valid = 1'b0;
    endtask

    task automatic send_pay(input int n, input logic [31:0] tag, input logic [7:0] last_keep,
                            input bit with_last);
        int w;
        for (int i = 0; i < n; i++) begin
            w = 0;
            s_axis_tdata  = {tag, 32'(i)};
            s_axis_tkeep  = (i == n - 1) ? last_keep : 8'hFF;
            s_axis_tlast  = with_last && (i == n - 1);
            s_axis_tvalid = 1'b1;
            @(negedge axis_aclk);
            while (!s_axis_tready && w < 4000) begin
                w++;
                @(negedge axis_aclk);
            end
            if (!s_axis_tready) begin
                total++; bad++;
                $display("FAIL pay_timeout act=no_ready req=ready beat=%0d", i);
                break;
            end
            exp_q.push_back({s_axis_tdata, s_axis_tkeep, 1'b0, s_axis_tlast});
            @(posedge axis_aclk); #1;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 6000) begin
            @(posedge axis_aclk);
            n++;
        end
        if (exp_q.size() != 0) begin
            total++; bad++;
            $display("FAIL drain_timeout act=%0d req=0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(posedge axis_aclk);
        #1;
    endtask

    initial begin
        // Reset state, with a header already pending.
        hdr_valid     = 1'b1;
        s_axis_tvalid = 1'b1;
        repeat (3) @(posedge axis_aclk);
        #1;
        chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("rst_tlast",  64'(m_axis_tlast),  64'd0);
        chk("rst_tuser",  64'(m_axis_tuser),  64'd0);
        chk("rst_tdata",  m_axis_tdata,       64'd0);
        chk("rst_tkeep",  64'(m_axis_tkeep),  64'd0);
        chk("rst_hdr_ready", 64'(hdr_ready),  64'd0);
        chk("rst_s_tready", 64'(s_axis_tready), 64'd0);
        chk("rst_pkt_count", 64'(pkt_count), 64'd0);
        chk("rst_wc_err", 64'(wc_err_count), 64'd0);
        hdr_valid     = 1'b0;
        s_axis_tvalid = 1'b0;
        axis_aresetn  = 1'b1;
        repeat (2) @(posedge axis_aclk);
        #1;

        // Short packet SOF: vc=1, wc=5; payload input must stay blocked.
        send_hdr(6'h00, 2'd1, 16'h0005, 64'h0000_0000_0000_0540, 1'b1);
        s_axis_tvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge axis_aclk);
            chk("short_s_tready", 64'(s_axis_tready), 64'd0);
        end
        @(posedge axis_aclk); #1;
        s_axis_tvalid = 1'b0;
        drain();
        chk("short_pkt_count", 64'(pkt_count), 64'(model_pkts));

        // Long packet RAW10, 600 beats.
        send_hdr(6'h2B, 2'd0, 16'd4800, 64'h0000_0000_0012_C02B, 1'b0);
        send_pay(600, 32'hA100_0000, 8'hFF, 1'b1);
        drain();
        chk("raw10_pkt_count", 64'(pkt_count), 64'(model_pkts));
        chk("raw10_wc_err", 64'(wc_err_count), 64'd0);

        // Data-type and word-count boundaries.
        send_hdr(6'h0F, 2'd0, 16'd8, 64'h0000_0000_0000_080F, 1'b1);
        send_hdr(6'h2B, 2'd1, 16'd0, 64'h0000_0000_0000_006B, 1'b1);
        send_hdr(6'h10, 2'd0, 16'd8, 64'h0000_0000_0000_0810, 1'b0);
        send_pay(1, 32'hB200_0000, 8'hFF, 1'b1);
        drain();
        chk("bound_pkt_count", 64'(pkt_count), 64'(model_pkts));

        // Backpressure: RAW12 with ready toggling.
        tgl_en = 1'b1;
        send_hdr(6'h2C, 2'd2, 16'd5760, 64'h0000_0000_0016_80AC, 1'b0);
        send_pay(720, 32'hC300_0000, 8'hFF, 1'b1);
        drain();
        tgl_en = 1'b0;
        repeat (2) @(posedge axis_aclk);
        #1;
        chk("bp_pkt_count", 64'(pkt_count), 64'(model_pkts));

        // Back-to-back: EOL header queued while a long packet finishes.
        fork
            begin
                send_hdr(6'h2A, 2'd0, 16'd16, 64'h0000_0000_0000_102A, 1'b0);
                send_pay(2, 32'hD400_0000, 8'hFF, 1'b1);
            end
            begin
                repeat (2) @(posedge axis_aclk);
                #1;
                send_hdr(6'h03, 2'd0, 16'd0, 64'h0000_0000_0000_0003, 1'b1);
            end
        join
        drain();
        chk("b2b_gap", 64'(hdr_cyc - pay_last_cyc), 64'd1);

        // Word-count check: one beat short, then an exact 13-byte packet.
        send_hdr(6'h2B, 2'd3, 16'd4800, 64'h0000_0000_0012_C0EB, 1'b0);
        send_pay(599, 32'hE500_0000, 8'hFF, 1'b1);
        drain();
        chk("wc_short_err", 64'(wc_err_count), 64'(WC_ERR_AFTER_SHORT));
        send_hdr(6'h2B, 2'd0, 16'd13, 64'h0000_0000_0000_0D2B, 1'b0);
        send_pay(2, 32'hF600_0000, 8'h1F, 1'b1);
        drain();
        chk("wc_exact_err", 64'(wc_err_count), 64'(WC_ERR_AFTER_SHORT));

        // Reset mid-packet at payload beat 100.
        send_hdr(6'h2B, 2'd0, 16'd4800, 64'h0000_0000_0012_C02B, 1'b0);
        send_pay(100, 32'h1700_0000, 8'hFF, 1'b0);
        axis_aresetn = 1'b0;
        #1;
        chk("midrst_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("midrst_tlast",  64'(m_axis_tlast),  64'd0);
        exp_q.delete();
        model_pkts = 0;
        repeat (2) @(posedge axis_aclk);
        #1;
        axis_aresetn = 1'b1;
        repeat (2) @(posedge axis_aclk);
        #1;
        chk("midrst_pkt_count", 64'(pkt_count), 64'd0);
        s_axis_tvalid = 1'b1;
        @(negedge axis_aclk);
        chk("midrst_idle_s_tready", 64'(s_axis_tready), 64'd0);
        @(posedge axis_aclk); #1;
        s_axis_tvalid = 1'b0;
        send_hdr(6'h01, 2'd0, 16'd7, 64'h0000_0000_0000_0701, 1'b1);
        drain();
        chk("midrst_new_pkt_count", 64'(pkt_count), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hsb_mipi_hdr_inserter.md
HSB_MIPI_HDR_INSERTER -- requirements
Module: hsb_mipi_hdr_inserter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; these ports SHALL be axis_aclk and axis_aresetn.
REQ-002 The block SHALL have parameter C_AXIS_TUSER_WIDTH, default 1: output tuser width; only bit 0 is driven and upper bits are 0.
REQ-003 The block SHALL have parameter C_AXIS_TDATA_WIDTH, default 64: data width; only the value 64 is supported.
REQ-004 The block SHALL have parameter LONG_DT_MIN, default 6'h10: data types at or above this value are long packets.
REQ-005 Ports (name, direction, width, meaning):
- axis_aclk  in  1  clock
- axis_aresetn  in  1  asynchronous active-low reset
- hdr_valid  in  1  packet header available
- hdr_ready  out  1  header consumed
- hdr_dt  in  6  CSI-2 data type
- hdr_vc  in  2  virtual channel
- hdr_wc  in  16  word count in bytes (long packets) or short-packet data
- s_axis_tdata  in  64  payload data
- s_axis_tkeep  in  8  payload byte enables
- s_axis_tvalid  in  1  payload valid
- s_axis_tready  out  1  payload ready
- s_axis_tlast  in  1  last payload beat
- m_axis_tdata  out  64  output data
- m_axis_tkeep  out  8  output byte enables
- m_axis_tuser  out  C_AXIS_TUSER_WIDTH  bit 0 marks the header beat
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  output ready
- m_axis_tlast  out  1  end of packet
- pkt_count  out  32  headers emitted
- wc_err_count  out  16  word-count mismatches

Function
REQ-006 Outputs SHALL be driven from a single registered output stage; the output stage is free when m_axis_tvalid=0 or m_axis_tready=1.
REQ-007 The FSM SHALL have two states, IDLE and PAYLOAD.
REQ-008 In IDLE, with hdr_valid=1 and the output stage free, the block SHALL assert hdr_ready for exactly that cycle and load the header beat.
REQ-009 Header beat format SHALL be: tdata[5:0]=hdr_dt, [7:6]=hdr_vc, [23:8]=hdr_wc, [63:24]=0; tkeep=8'hFF; tuser[0]=1.
REQ-010 If hdr_dt<LONG_DT_MIN, or hdr_wc=0, the header beat SHALL carry tlast=1 and the FSM SHALL remain in IDLE; otherwise tlast=0 and the FSM SHALL go to PAYLOAD.
REQ-011 s_axis_tready SHALL be 1 only in PAYLOAD while the output stage is free; it SHALL be 0 in IDLE.
REQ-012 Payload beats SHALL pass with tdata, tkeep and tlast unchanged and tuser[0]=0, with one cycle of latency from acceptance to m_axis_tvalid.
REQ-013 Acceptance of a beat with s_axis_tlast=1 SHALL return the FSM to IDLE; the next header can be loaded on the following cycle.
REQ-014 hdr_ready SHALL be 0 throughout PAYLOAD, and headers SHALL never interleave with payload.
REQ-015 Sustained throughput SHALL be one beat per clock with m_axis_tready=1, with no bubble between a tlast beat and the next header.
REQ-016 When m_axis_tready=0, m_axis_tvalid=1, the output stage SHALL hold tdata, tkeep, tuser and tlast stable.
REQ-017 pkt_count SHALL increment by 1 on each header beat load and wrap at 2^32.

Reset
REQ-018 While axis_aresetn=0: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tuser=0, m_axis_tdata=0, m_axis_tkeep=0, hdr_ready=0, s_axis_tready=0, FSM=IDLE, pkt_count=0, wc_err_count=0.
REQ-019 On reset mid-packet, the partial packet SHALL be abandoned; after release the block SHALL wait in IDLE for a new header and SHALL emit no tlast for the old packet.

Configuration
REQ-020 Macro HSB_MIPI_HDR_INS_WC_CHECK_EN defined: in PAYLOAD the block SHALL count accepted beats.
- Expected beat count = ceil(wc/8).
- On tlast, if the beat count differs from the expected count, or popcount(tkeep) differs from wc mod 8 (0 meaning 8), wc_err_count SHALL increment, saturating at 16'hFFFF.
- Data flow is unaffected.
REQ-021 Macro undefined: no checking logic; wc_err_count SHALL be constant 0.

Verification
REQ-022 Short packet: dt=0x00 (SOF), vc=1, wc=0x0005 -> one beat, tdata=64'h0000_0000_0000_0540, tuser=1, tlast=1, tkeep=FF; s_axis_tready stays 0.
REQ-023 Long packet RAW10: dt=0x2B, wc=4800, 600 payload beats with tlast on beat 600 -> 601 output beats, header tuser=1, tlast only on beat 601, pkt_count=1, wc_err_count=0.
REQ-024 Backpressure: m_axis_tready toggling 1010... during a RAW12 packet (wc=5760) -> no beat lost or duplicated; data stable while stalled; order preserved.
REQ-025 Back-to-back: EOL short header queued while a long packet ends -> EOL header appears on the cycle right after the payload tlast beat.
REQ-026 With HSB_MIPI_HDR_INS_WC_CHECK_EN: wc=4800, tlast on beat 599 -> wc_err_count=1; wc=13 with last tkeep=8'h1F over 2 beats -> no increment.
REQ-027 Reset asserted at payload beat 100 -> m_axis_tvalid=0 immediately; after release, a new header emits normally and pkt_count restarts from 0.
